// File: rtl/flappy_pkg.sv
// Shared types and screen constants for the flappy game objects.
package flappy_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned SPEED_W   = 3;
    localparam int unsigned SPEED_MAX = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1, free-running, seeded to 1.
module lfsr10 (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] q
);

    // Shift every non-reset cycle; maximal-length taps keep the state non-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 10'h001;
        end else begin
            q <= {q[8:0], q[9] ^ q[6]};
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls one pipe leftward at a frame tick, wraps it with a random gap height,
// and pulses 'passed' when its trailing edge clears the bird column.
// Optional build macro PIPE_SPEEDUP_EN: speed rises by one every four passes (max 4).
// Parameters must satisfy Y_MIN + 255 + GAP_H <= 479 so the gap stays on screen.
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int unsigned X_START    = 640,
    parameter int unsigned PIPE_W     = 40,
    parameter int unsigned GAP_H      = 120,
    parameter int unsigned Y_MIN      = 40,
    parameter int unsigned BIRD_X     = 100,
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned SPEED_INIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    output logic [COORD_W-1:0] pipe_x,
    output logic [COORD_W-1:0] gap_top,
    output logic [COORD_W-1:0] gap_bot,
    output logic               passed,
    output logic               running
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    scroll_state_t       state, state_n;
    logic [TICK_W-1:0]   tick, tick_n;
    coord_t              pipe_x_n, gap_top_n, new_x, gap_new;
    logic                passed_n;
    logic [SPEED_W-1:0]  speed;
    logic [9:0]          lfsr_q;
    logic                lfsr_unused;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Only the low byte randomises the gap; upper bits are deliberately dropped.
    assign lfsr_unused = ^lfsr_q[9:8];
    assign gap_new     = COORD_W'(Y_MIN) + COORD_W'(lfsr_q[7:0]);

    // Next-state and next-output logic; halt wins over start and over a due step.
    always_comb begin
        state_n   = state;
        tick_n    = tick;
        pipe_x_n  = pipe_x;
        gap_top_n = gap_top;
        passed_n  = 1'b0;
        new_x     = pipe_x - COORD_W'(speed);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (tick == TICK_W'(TICK_DIV - 1)) begin
                    tick_n = '0;
                    if (pipe_x < COORD_W'(speed)) begin
                        pipe_x_n  = COORD_W'(X_START);
                        gap_top_n = gap_new;
                    end else begin
                        pipe_x_n = new_x;
                        passed_n = ((11'(pipe_x) + 11'(PIPE_W)) >= 11'(BIRD_X)) &&
                                   ((11'(new_x)  + 11'(PIPE_W)) <  11'(BIRD_X));
                    end
                end else begin
                    tick_n = tick + TICK_W'(1);
                end
            end
            HALTED: begin
                if (start) begin
                    state_n   = RUN;
                    tick_n    = '0;
                    pipe_x_n  = COORD_W'(X_START);
                    gap_top_n = gap_new;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; gap_bot is registered alongside gap_top.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            pipe_x  <= COORD_W'(X_START);
            gap_top <= COORD_W'(Y_MIN);
            gap_bot <= COORD_W'(Y_MIN + GAP_H);
            passed  <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            pipe_x  <= pipe_x_n;
            gap_top <= gap_top_n;
            gap_bot <= gap_top_n + COORD_W'(GAP_H);
            passed  <= passed_n;
            running <= (state_n == RUN);
        end
    end

`ifdef PIPE_SPEEDUP_EN
    logic [1:0] pass_cnt;
    logic       relaunch;

    assign relaunch = (state == HALTED) && start;

    // Every fourth pass raises the step size, saturating at SPEED_MAX.
    always_ff @(posedge clk) begin
        if (reset || relaunch) begin
            pass_cnt <= '0;
            speed    <= SPEED_W'(SPEED_INIT);
        end else if (passed_n) begin
            pass_cnt <= pass_cnt + 2'd1;
            if ((pass_cnt == 2'd3) && (speed < SPEED_W'(SPEED_MAX))) begin
                speed <= speed + SPEED_W'(1);
            end
        end
    end
`else
    assign speed = SPEED_W'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed, scoreboard-based bench for pipe_scroller with TICK_DIV=2.
module tb_pipe_scroller;

    localparam int unsigned TD = 2;
`ifdef PIPE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic [9:0] pipe_x, gap_top, gap_bot;
    logic       passed, running;

    pipe_scroller #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .halt    (halt),
        .pipe_x  (pipe_x),
        .gap_top (gap_top),
        .gap_bot (gap_bot),
        .passed  (passed),
        .running (running)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_prev is the value seen by the DUT at the latest edge.
    logic [9:0] m_lfsr = 10'h001;
    logic [9:0] m_prev = 10'h001;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (reset) m_lfsr <= 10'h001;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    typedef struct packed {
        logic [9:0] x;
        logic       pass;
        logic       wrap;
    } step_t;

    step_t      sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [9:0] cur_x;
    logic [9:0] exp_gap;
    int         exp_speed;
    int         pass_seen;
    int         x_mark;
    int         guard;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push the expected result of the next step, wait for it, then pop and compare.
    task automatic step_check();
        step_t e;
        int    waited;
        e.wrap = (int'(cur_x) < exp_speed);
        e.x    = e.wrap ? 10'd640 : cur_x - 10'(exp_speed);
        e.pass = !e.wrap && ((int'(cur_x) + 40) >= 100) && ((int'(e.x) + 40) < 100);
        sb.push_back(e);
        waited = 0;
        while (waited < 2 * TD) begin
            tick();
            waited++;
            if (pipe_x !== cur_x) break;
            chk("passed_idle", 32'(passed), 32'd0);
        end
        chk("step_period", 32'(waited), 32'(TD));
        e = sb.pop_front();
        if (e.wrap) exp_gap = 10'd40 + 10'(m_prev[7:0]);
        chk("step_x", 32'(pipe_x), 32'(e.x));
        chk("step_passed", 32'(passed), 32'(e.pass));
        chk("step_gap_top", 32'(gap_top), 32'(exp_gap));
        chk("step_gap_bot", 32'(gap_bot), 32'(exp_gap) + 32'd120);
        chk("step_running", 32'(running), 32'd1);
        cur_x = e.x;
        if (e.pass) begin
            pass_seen++;
            if (SPEEDUP && (pass_seen % 4 == 0) && (exp_speed < 4)) exp_speed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_x", 32'(pipe_x), 32'd640);
        chk("rst_gap_top", 32'(gap_top), 32'd40);
        chk("rst_gap_bot", 32'(gap_bot), 32'd160);
        chk("rst_passed", 32'(passed), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_running", 32'(running), 32'd0);
        chk("idle_x", 32'(pipe_x), 32'd640);

        // Start and first steps
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_running", 32'(running), 32'd1);
        chk("start_x", 32'(pipe_x), 32'd640);
        cur_x = 10'd640; exp_gap = 10'd40; exp_speed = 1; pass_seen = 0;
        step_check();
        step_check();

        // Pass at 60 -> 59, then wrap at 0
        while (cur_x != 10'd60) step_check();
        step_check();
        while (cur_x != 10'd0) step_check();
        step_check();
        chk("wrap_x", 32'(cur_x), 32'd640);

        // Halt with coincident start and due step
        while (cur_x != 10'd300) step_check();
        tick();
        halt  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_running", 32'(running), 32'd0);
        chk("halt_x", 32'(pipe_x), 32'd300);
        chk("halt_passed", 32'(passed), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold_x", 32'(pipe_x), 32'd300);
            chk("halt_hold_running", 32'(running), 32'd0);
            chk("halt_hold_gap", 32'(gap_top), 32'(exp_gap));
        end
        halt  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_gap = 10'd40 + 10'(m_prev[7:0]);
        chk("relaunch_x", 32'(pipe_x), 32'd640);
        chk("relaunch_running", 32'(running), 32'd1);
        chk("relaunch_gap_top", 32'(gap_top), 32'(exp_gap));
        chk("relaunch_gap_bot", 32'(gap_bot), 32'(exp_gap) + 32'd120);
        cur_x = 10'd640; exp_speed = 1; pass_seen = 0;
        step_check();

        // Reset mid-run, with start high
        while (cur_x != 10'd200) step_check();
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("midrst_x", 32'(pipe_x), 32'd640);
        chk("midrst_gap_top", 32'(gap_top), 32'd40);
        chk("midrst_gap_bot", 32'(gap_bot), 32'd160);
        chk("midrst_running", 32'(running), 32'd0);
        chk("midrst_passed", 32'(passed), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("midrst_idle_running", 32'(running), 32'd0);
        chk("midrst_idle_x", 32'(pipe_x), 32'd640);

        // Step size after 4 and 16 passes
        start = 1'b1;
        tick();
        start = 1'b0;
        cur_x = 10'd640; exp_gap = 10'd40; exp_speed = 1; pass_seen = 0;
        guard = 0;
        while (pass_seen < 4 && guard < 4000) begin
            step_check();
            guard++;
        end
        chk("four_passes", 32'(pass_seen), 32'd4);
        x_mark = int'(cur_x);
        step_check();
        chk("speed_after_4", 32'(x_mark - int'(pipe_x)), SPEEDUP ? 32'd2 : 32'd1);
        guard = 0;
        while (pass_seen < 16 && guard < 12000) begin
            step_check();
            guard++;
        end
        chk("sixteen_passes", 32'(pass_seen), 32'd16);
        x_mark = int'(cur_x);
        step_check();
        chk("speed_after_16", 32'(x_mark - int'(pipe_x)), SPEEDUP ? 32'd4 : 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
